// File: rtl/mem_stage_lsu_if.sv
// MEM-stage LSU port bundle: EX/MEM instruction fields, data-memory req/ack bus, stall/result back to the pipe.
// The master side is the LSU itself; the slave side is the surrounding pipeline and memory.
interface mem_stage_lsu_if;
   logic        flush;
   logic        i_valid;
   logic        i_LD_ready;
   logic        i_SD_ready;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_store_data;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [31:0] o_dmem_wdata;
   logic [3:0]  o_dmem_be;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;
   logic        o_stall;
   logic [31:0] o_data_mem_loaded;
   logic        o_done;
   logic        o_fault;

   modport master (
      input  flush, i_valid, i_LD_ready, i_SD_ready, i_funct3, i_addr, i_store_data,
      input  i_dmem_ack, i_dmem_rdata,
      output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
      output o_stall, o_data_mem_loaded, o_done, o_fault
   );

   modport slave (
      output flush, i_valid, i_LD_ready, i_SD_ready, i_funct3, i_addr, i_store_data,
      output i_dmem_ack, i_dmem_rdata,
      input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
      input  o_stall, o_data_mem_loaded, o_done, o_fault
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/ack data-memory access per instruction, min 3 cycles (accept, BUSY, DONE).
// Stalls the upstream pipe while the access is outstanding; bad accesses fault without a bus request.
module mem_stage_lsu #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic           clk,
   input  logic           rst,
   mem_stage_lsu_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic        mem_op, misalign, bad_f3, start_bad, start_ok, expire;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt, ext, byte_sh;
   logic [15:0] half;
   logic [15:0] cnt;
   logic        kill, fault_q, we_q;
   logic [31:0] addr_q, wdata_q, loaded_q;
   logic [3:0]  be_q;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;

   // Start decode and store lane steering from the live EX/MEM fields
   always_comb begin
      mem_op   = bus.i_valid & (bus.i_LD_ready | bus.i_SD_ready) & ~bus.flush;
      misalign = 1'b0;
      case (bus.i_funct3[1:0])
         2'd1:    misalign = bus.i_addr[0];
         2'd2:    misalign = (bus.i_addr[1:0] != 2'd0);
         default: misalign = 1'b0;
      endcase
      if (bus.i_LD_ready)
         bad_f3 = (bus.i_funct3 == 3'd3) | (bus.i_funct3 >= 3'd6);
      else
         bad_f3 = (bus.i_funct3 >= 3'd3);
      start_bad = mem_op & ((bus.i_LD_ready & bus.i_SD_ready) | bad_f3 | misalign);
      start_ok  = mem_op & ~start_bad;

      be_nxt    = 4'hF;
      wdata_nxt = bus.i_store_data;
      if (bus.i_SD_ready) begin
         case (bus.i_funct3[1:0])
            2'd0: begin
               be_nxt    = 4'b0001 << bus.i_addr[1:0];
               wdata_nxt = {4{bus.i_store_data[7:0]}};
            end
            2'd1: begin
               be_nxt    = bus.i_addr[1] ? 4'b1100 : 4'b0011;
               wdata_nxt = {2{bus.i_store_data[15:0]}};
            end
            default: begin
               be_nxt    = 4'hF;
               wdata_nxt = bus.i_store_data;
            end
         endcase
      end
   end

   // Load extension uses the offset and funct3 captured at accept time
   always_comb begin
      byte_sh = bus.i_dmem_rdata >> {lo_q, 3'b000};
      half    = lo_q[1] ? bus.i_dmem_rdata[31:16] : bus.i_dmem_rdata[15:0];
      case (f3_q)
         3'd0:    ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
         3'd4:    ext = {24'd0, byte_sh[7:0]};
         3'd1:    ext = {{16{half[15]}}, half};
         3'd5:    ext = {16'd0, half};
         default: ext = bus.i_dmem_rdata;
      endcase
   end

   // An ack on the expiry cycle takes priority over the timeout
   assign expire = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST) && !bus.i_dmem_ack;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_ok) state_nxt = BUSY;
         BUSY: begin
            if (bus.i_dmem_ack)  state_nxt = (kill | bus.flush) ? IDLE : DONE;
            else if (expire)     state_nxt = IDLE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.o_dmem_req        = (state == BUSY);
      bus.o_stall           = (state == BUSY) | ((state == IDLE) & start_ok);
      bus.o_done            = (state == DONE) & ~bus.flush;
      bus.o_fault           = fault_q;
      bus.o_dmem_we         = we_q;
      bus.o_dmem_addr       = addr_q;
      bus.o_dmem_wdata      = wdata_q;
      bus.o_dmem_be         = be_q;
      bus.o_data_mem_loaded = loaded_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         kill     <= 1'b0;
         fault_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         f3_q     <= '0;
         lo_q     <= '0;
         loaded_q <= '0;
      end else begin
         fault_q <= ((state == IDLE) & start_bad) | ((state == BUSY) & expire);
         if (state == IDLE && start_ok) begin
            we_q    <= bus.i_SD_ready;
            addr_q  <= {bus.i_addr[31:2], 2'b00};
            wdata_q <= wdata_nxt;
            be_q    <= be_nxt;
            f3_q    <= bus.i_funct3;
            lo_q    <= bus.i_addr[1:0];
            cnt     <= '0;
            kill    <= 1'b0;
         end
         if (state == BUSY) begin
            cnt <= cnt + 16'd1;
            if (bus.flush) kill <= 1'b1;
            if (bus.i_dmem_ack && !kill && !bus.flush && !we_q) loaded_q <= ext;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: transaction model predicts every cycle of one instance (no timeout),
// directed sequences exercise the timeout and reset paths on a second instance (TIMEOUT_CYCLES=3).
module tb_mem_stage_lsu;
   logic clk = 1'b0;
   logic rst0, rst3;
   always #5 clk = ~clk;

   mem_stage_lsu_if b0();
   mem_stage_lsu_if b3();

   mem_stage_lsu #(.TIMEOUT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(b0));
   mem_stage_lsu #(.TIMEOUT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

   int n_chk = 0;
   int n_fail = 0;

   logic        mon_en;
   logic        exp_req, exp_stall, exp_done, exp_fault, exp_we;
   logic [31:0] exp_addr, exp_wdata, exp_loaded;
   logic [3:0]  exp_be;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit model_bad(input bit ld, input bit sd, input logic [2:0] f3, input logic [31:0] a);
      if (ld && sd) return 1'b1;
      if (ld) begin
         case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return a[0];
            3'd2:       return a[1:0] != 2'd0;
            default:    return 1'b1;
         endcase
      end
      case (f3)
         3'd0:    return 1'b0;
         3'd1:    return a[0];
         3'd2:    return a[1:0] != 2'd0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
      h = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
         3'd4:    return b;
         3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
         3'd5:    return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input bit sd, input logic [2:0] f3, input logic [31:0] a);
      if (!sd) return 4'hF;
      case (f3)
         3'd0:    return 4'(1 << a[1:0]);
         3'd1:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'd0:    return {24'd0, d[7:0]} * 32'h01010101;
         3'd1:    return {16'd0, d[15:0]} * 32'h00010001;
         default: return d;
      endcase
   endfunction

   // Per-cycle compare of the untimed instance against the model's expectations
   always @(negedge clk) begin
      if (mon_en) begin
         chk("req", b0.o_dmem_req, exp_req);
         chk("stall", b0.o_stall, exp_stall);
         chk("done", b0.o_done, exp_done);
         chk("fault", b0.o_fault, exp_fault);
         chk("loaded", b0.o_data_mem_loaded, exp_loaded);
         chk("done_fault_excl", b0.o_done & b0.o_fault, 1'b0);
         if (exp_req) begin
            chk("addr", b0.o_dmem_addr, exp_addr);
            chk("we", b0.o_dmem_we, exp_we);
            chk("be", b0.o_dmem_be, exp_be);
            if (exp_we) chk("wdata", b0.o_dmem_wdata, exp_wdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_all();
      b0.i_valid = 0; b0.i_LD_ready = 0; b0.i_SD_ready = 0; b0.flush = 0;
      b0.i_dmem_ack = 0;
      exp_req = 0; exp_stall = 0; exp_done = 0; exp_fault = 0;
   endtask

   task automatic access(input bit ld, input bit sd, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int wt, input logic [31:0] rd,
                         input int flush_k, input bit flush_done, input bit flush_idle);
      bit bad, killed;
      bad = (ld | sd) ? model_bad(ld, sd, f3, a) : 1'b0;
      killed = 0;
      step();
      b0.i_valid = 1; b0.i_LD_ready = ld; b0.i_SD_ready = sd; b0.i_funct3 = f3;
      b0.i_addr = a; b0.i_store_data = d; b0.flush = flush_idle;
      exp_req = 0; exp_done = 0; exp_fault = 0;
      exp_stall = (ld | sd) & !bad & !flush_idle;
      if ((ld | sd) && !bad && !flush_idle) begin
         exp_addr = {a[31:2], 2'b00}; exp_we = sd;
         exp_be = model_be(sd, f3, a); exp_wdata = model_wd(f3, d);
      end
      step();
      b0.i_valid = 0; b0.i_LD_ready = 0; b0.i_SD_ready = 0; b0.flush = 0;
      b0.i_addr = $urandom; b0.i_funct3 = 3'($urandom);
      if (!(ld | sd) || flush_idle) begin
         exp_stall = 0;
      end else if (bad) begin
         exp_fault = 1; exp_stall = 0;
      end else begin
         for (int k = 0; k <= wt; k++) begin
            if (k > 0) step();
            exp_req = 1; exp_stall = 1;
            b0.flush = (k == flush_k);
            if (k == flush_k) killed = 1;
            b0.i_dmem_ack = (k == wt);
            b0.i_dmem_rdata = (k == wt) ? rd : $urandom;
         end
         step();
         b0.i_dmem_ack = 0; b0.flush = flush_done;
         exp_req = 0; exp_stall = 0;
         if (!killed) begin
            exp_done = !flush_done;
            if (!sd) exp_loaded = model_ext(f3, a, rd);
         end
      end
      step();
      idle_all();
   endtask

   task automatic chk3(input string nm, input bit req, input bit stall, input bit done,
                       input bit fault, input logic [31:0] loaded);
      @(negedge clk);
      #1;
      chk({nm, "_req"}, b3.o_dmem_req, req);
      chk({nm, "_stall"}, b3.o_stall, stall);
      chk({nm, "_done"}, b3.o_done, done);
      chk({nm, "_fault"}, b3.o_fault, fault);
      chk({nm, "_loaded"}, b3.o_data_mem_loaded, loaded);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] f3;
      logic [31:0] a;
      int r, wt, fk;
      rst0 = 1; rst3 = 1; mon_en = 0;
      exp_addr = 0; exp_wdata = 0; exp_loaded = 0; exp_be = 0; exp_we = 0;
      idle_all();
      b0.i_funct3 = 0; b0.i_addr = 0; b0.i_store_data = 0; b0.i_dmem_rdata = 0;
      b3.flush = 0; b3.i_valid = 0; b3.i_LD_ready = 0; b3.i_SD_ready = 0; b3.i_funct3 = 0;
      b3.i_addr = 0; b3.i_store_data = 0; b3.i_dmem_ack = 0; b3.i_dmem_rdata = 0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_req", b0.o_dmem_req, 0);
      chk("rst_addr", b0.o_dmem_addr, 0);
      chk("rst_wdata", b0.o_dmem_wdata, 0);
      chk("rst_be", b0.o_dmem_be, 0);
      chk("rst_loaded", b0.o_data_mem_loaded, 0);
      chk("rst_done", b0.o_done | b0.o_fault | b0.o_stall | b0.o_dmem_we, 0);
      step();
      rst0 = 0; rst3 = 0; mon_en = 1;

      chk("pin_lb", model_ext(3'd0, 32'h103, 32'h80FFFF7F), 32'hFFFFFF80);
      chk("pin_lbu", model_ext(3'd4, 32'h103, 32'h80FFFF7F), 32'h00000080);
      chk("pin_lhu", model_ext(3'd5, 32'h102, 32'h80FFFF7F), 32'h000080FF);
      chk("pin_sb_be", model_be(1'b1, 3'd0, 32'h201), 4'b0010);
      chk("pin_sb_wd", model_wd(3'd0, 32'h123456AB), 32'hABABABAB);

      access(1, 0, 3'd2, 32'h100, 0, 0, 32'hDEADBEEF, -1, 0, 0);
      @(negedge clk);
      chk("lw_literal", b0.o_data_mem_loaded, 32'hDEADBEEF);
      access(1, 0, 3'd0, 32'h103, 0, 0, 32'h80FFFF7F, -1, 0, 0);
      @(negedge clk);
      chk("lb_literal", b0.o_data_mem_loaded, 32'hFFFFFF80);
      access(1, 0, 3'd4, 32'h103, 0, 1, 32'h80FFFF7F, -1, 0, 0);
      access(1, 0, 3'd5, 32'h102, 0, 0, 32'h80FFFF7F, -1, 0, 0);
      access(0, 1, 3'd0, 32'h201, 32'h123456AB, 0, 32'h11111111, -1, 0, 0);
      @(negedge clk);
      chk("sb_keeps_loaded", b0.o_data_mem_loaded, 32'h000080FF);
      access(1, 0, 3'd2, 32'h102, 0, 0, 0, -1, 0, 0);
      access(0, 1, 3'd1, 32'h101, 32'h5555, 0, 0, -1, 0, 0);
      access(1, 1, 3'd2, 32'h100, 0, 0, 0, -1, 0, 0);
      access(1, 0, 3'd6, 32'h100, 0, 0, 0, -1, 0, 0);
      access(1, 0, 3'd1, 32'h300, 0, 4, 32'h9999_8888, 1, 0, 0);
      access(1, 0, 3'd2, 32'h304, 0, 2, 32'h7777_6666, -1, 1, 0);
      access(1, 0, 3'd2, 32'h308, 0, 0, 32'h1234_5678, -1, 0, 1);
      access(0, 0, 3'd2, 32'h30C, 0, 0, 0, -1, 0, 0);

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
              ((r >= 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) + (($urandom_range(0, 1) == 1) ? 0 : 4)));
         if (f3 == 3'd6) f3 = 3'd2;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         wt = $urandom_range(0, 3);
         fk = ($urandom_range(0, 9) == 0) ? $urandom_range(0, wt) : -1;
         access(r >= 1 && r <= 5, r == 1 || r >= 6, f3, a, $urandom, wt, $urandom, fk,
                $urandom_range(0, 14) == 0, $urandom_range(0, 19) == 0);
      end

      // Timeout instance: ack on the expiry cycle completes normally
      step();
      b3.i_valid = 1; b3.i_LD_ready = 1; b3.i_funct3 = 3'd2; b3.i_addr = 32'h40;
      chk3("t_acc", 0, 1, 0, 0, 0);
      step();
      b3.i_valid = 0; b3.i_LD_ready = 0;
      chk3("t_b1", 1, 1, 0, 0, 0);
      step();
      chk3("t_b2", 1, 1, 0, 0, 0);
      step();
      b3.i_dmem_ack = 1; b3.i_dmem_rdata = 32'hCAFEF00D;
      chk3("t_b3ack", 1, 1, 0, 0, 0);
      step();
      b3.i_dmem_ack = 0;
      chk3("t_done", 0, 0, 1, 0, 32'hCAFEF00D);
      step();
      chk3("t_idle", 0, 0, 0, 0, 32'hCAFEF00D);

      // No ack: three BUSY cycles then fault
      step();
      b3.i_valid = 1; b3.i_LD_ready = 1; b3.i_funct3 = 3'd2; b3.i_addr = 32'h44;
      chk3("to_acc", 0, 1, 0, 0, 32'hCAFEF00D);
      step();
      b3.i_valid = 0; b3.i_LD_ready = 0;
      chk3("to_b1", 1, 1, 0, 0, 32'hCAFEF00D);
      step();
      chk3("to_b2", 1, 1, 0, 0, 32'hCAFEF00D);
      step();
      chk3("to_b3", 1, 1, 0, 0, 32'hCAFEF00D);
      step();
      chk3("to_fault", 0, 0, 0, 1, 32'hCAFEF00D);
      step();
      chk3("to_after", 0, 0, 0, 0, 32'hCAFEF00D);

      // Reset in mid-BUSY, then a stray ack
      step();
      b3.i_valid = 1; b3.i_SD_ready = 1; b3.i_funct3 = 3'd2; b3.i_addr = 32'h48;
      b3.i_store_data = 32'hA5A5A5A5;
      chk3("r_acc", 0, 1, 0, 0, 32'hCAFEF00D);
      step();
      b3.i_valid = 0; b3.i_SD_ready = 0;
      chk3("r_b1", 1, 1, 0, 0, 32'hCAFEF00D);
      step();
      rst3 = 1;
      chk3("r_b2", 1, 1, 0, 0, 32'hCAFEF00D);
      step();
      rst3 = 0;
      chk3("r_post", 0, 0, 0, 0, 0);
      chk("r_post_we", b3.o_dmem_we, 0);
      chk("r_post_addr", b3.o_dmem_addr, 0);
      chk("r_post_wdata", b3.o_dmem_wdata, 0);
      chk("r_post_be", b3.o_dmem_be, 0);
      step();
      b3.i_dmem_ack = 1; b3.i_dmem_rdata = 32'h0BAD0BAD;
      chk3("r_stray", 0, 0, 0, 0, 0);
      step();
      b3.i_dmem_ack = 0;
      chk3("r_stray_after", 0, 0, 0, 0, 0);

      step();
      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit for the riscv32i pipeline. It consumes the EX/MEM pipeline register fields (LD_ready, SD_ready, alu_res1 as the address, op2_reg as the store data, funct3 from instruct) and runs one data-memory transaction per instruction over a req/ack bus. It returns the aligned, extended load result as data_mem_loaded, which feeds the MEM/WB pipeline register. It drives a stall that holds the upstream pipeline registers' `en` low while a transaction is outstanding.

## Interface
- TIMEOUT_CYCLES, 0, max BUSY cycles without ack before fault; 0 disables the timeout (16-bit counter)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  sync, active-high; kills the current MEM-stage instruction
- i_valid  in  1  EX/MEM register holds a live instruction
- i_LD_ready  in  1  instruction is a load
- i_SD_ready  in  1  instruction is a store
- i_funct3  in  3  instruct[14:12]
- i_addr  in  32  byte address (alu_res1)
- i_store_data  in  32  store source (op2_reg)
- o_dmem_req  out  1  bus request, held until ack
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  32  word address, {addr[31:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_ack  in  1  one-cycle transaction complete
- i_dmem_rdata  in  32  read word, valid with ack
- o_stall  out  1  hold upstream pipe registers (en = ~o_stall)
- o_data_mem_loaded  out  32  extended load result
- o_done  out  1  one-cycle pulse: access completed
- o_fault  out  1  one-cycle pulse: misaligned, illegal funct3, LD&SD both set, or timeout

## Operation
- FSM states: IDLE, BUSY, DONE.
- Start condition, evaluated in IDLE: i_valid & (LD|SD) & ~flush.
  - Legal start: latch we, word address, wdata, be, funct3 and addr[1:0]. o_stall=1 (combinational). Next state BUSY.
  - Faulting start: LD&SD both set; LW or SW with addr[1:0]≠0; LH, LHU or SH with addr[0]≠0; load funct3 ∈ {3,6,7}; store funct3 ≥ 3. Response: o_fault pulses the next cycle, no request is issued, no stall, state stays IDLE.
- BUSY:
  - o_dmem_req=1; o_stall=1; address, wdata, be and we are stable.
  - On ack: a load writes the extended result into o_data_mem_loaded; next state DONE.
- DONE: o_stall=0, o_done=1, next state IDLE. The upstream registers advance this cycle, so the same instruction is never restarted.
- Load extension:
  - LB/LBU: byte addr[1:0], sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: full word.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - SW: be=4'hF, wdata=data.
- flush in BUSY:
  - The kill flag is set. The request is not retracted; the unit waits for ack.
  - On ack: go to IDLE directly. No o_done, o_data_mem_loaded unchanged.
- flush in DONE: o_done is suppressed and the load data write has already happened. The MEM/WB register is flushed externally.
- Timeout (TIMEOUT_CYCLES=N>0):
  - The counter clears on entry to BUSY.
  - After N BUSY cycles with no ack: drop req, pulse o_fault, go to IDLE, data unchanged.
  - An ack in the same cycle as expiry wins, and the access completes normally.
- rst (any state): state=IDLE, kill=0, counter=0. An in-flight bus transaction is abandoned. A late ack is ignored in IDLE.

## Timing
- Reset values: o_dmem_req=0, o_dmem_we=0, o_dmem_addr=0, o_dmem_wdata=0, o_dmem_be=0, o_stall=0, o_data_mem_loaded=0, o_done=0, o_fault=0.
- Minimum occupancy is 3 cycles: IDLE accept (stall), BUSY with ack the same cycle, DONE (data valid, stall low).
- Each extra wait cycle before ack adds one BUSY cycle.
- o_data_mem_loaded is registered and updates on the clock edge after ack. It holds between loads; stores do not change it.
- o_done and o_fault are registered and never high together.
- Non-memory instructions pass with zero stall.

## Test plan
- LW at 0x100, ack on first BUSY cycle, rdata=0xDEADBEEF: stall is high for 2 cycles; the DONE cycle shows o_done=1 and o_data_mem_loaded=0xDEADBEEF; dmem_addr=0x100, be=4'hF, we=0.
- LB at 0x103 with rdata=0x80FF_FF7F gives 0xFFFFFF80. LBU at 0x103 gives 0x00000080. LHU at 0x102 gives 0x000080FF.
- SB at 0x201 with data 0x1234_56AB: be=4'b0010, wdata=0xABABABAB, we=1. o_data_mem_loaded is unchanged after o_done.
- LW at 0x102: o_fault pulses once, o_dmem_req never rises, o_stall stays 0. Repeat for SH at 0x101 and for LD&SD both set.
- LH with ack delayed 4 cycles and flush asserted in the second BUSY cycle: req stays high until ack, then state returns to IDLE with no o_done and o_data_mem_loaded unchanged.
- Two cases with TIMEOUT_CYCLES=3:
  - No ack: after 3 BUSY cycles req drops, o_fault pulses, stall releases.
  - rst in mid-BUSY of a separate access: all outputs return to their reset values the next cycle, and a later stray ack is ignored.
